// File: rtl/tree_serializer_hs_pkg.sv
// ============================================================================
// tree_ser_pkg : shared types and helpers for the tree serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package tree_ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Per-rank framing flags that ride alongside the mux tree.
  typedef struct packed {
    logic valid;
    logic first;
  } flag_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tree_ser_stage.sv
// ============================================================================
// tree_ser_stage : one registered 2:1 rank of the serializer mux tree
// Rev 1.0
// ============================================================================
`default_nettype none

module tree_ser_stage #(
  parameter int WIDTH_IN = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SEL,
  input  logic [WIDTH_IN-1:0]   D,
  output logic [WIDTH_IN/2-1:0] Q
);

  logic [WIDTH_IN/2-1:0] q_q;
  logic [WIDTH_IN/2-1:0] q_d;

  always_comb begin
    q_d = '0;
    for (int i = 0; i < WIDTH_IN / 2; i++) begin
      q_d[i] = SEL ? D[2*i+1] : D[2*i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

`default_nettype wire

// File: rtl/tree_serializer_hs.sv
// ============================================================================
// tree_serializer_hs : single-clock N:1 pipelined tree serializer, valid/ready load
// Rev 1.0
// ============================================================================
`default_nettype none

module tree_serializer_hs
  import tree_ser_pkg::*;
#(
  parameter int INPUTS_NUM = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INPUTS_NUM-1:0] PAR_IN,
  input  logic                  PAR_VALID,
  output logic                  PAR_READY,
  input  logic                  MSB_FIRST,
  output logic                  SERIAL_OUT,
  output logic                  SERIAL_VALID,
  output logic                  SERIAL_FIRST,
  output logic                  UNDERRUN
);

  localparam int STAGES_NUM = $clog2(INPUTS_NUM);
  localparam int TREE_W     = 2 * INPUTS_NUM - 1;
  localparam logic [STAGES_NUM-1:0] CNT_LAST = STAGES_NUM'(INPUTS_NUM - 1);

  if (!is_pow2(INPUTS_NUM) || (INPUTS_NUM < 2)) begin : g_param_check
    $error("tree_serializer_hs: INPUTS_NUM must be a power of 2 and >= 2");
  end

  state_t                  state_q, state_d;
  logic [STAGES_NUM-1:0]   cnt_q, cnt_d;
  logic [INPUTS_NUM-1:0]   word_q, word_d;
  logic                    under_q, under_d;
  logic                    busy, at_last, accept;

  assign busy      = (state_q == ST_SHIFT);
  assign at_last   = (cnt_q == CNT_LAST);
  assign PAR_READY = ~RESET & (~busy | at_last);
  assign accept    = PAR_VALID & PAR_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    under_d = 1'b0;
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      for (int i = 0; i < INPUTS_NUM; i++) begin
        word_d[i] = MSB_FIRST ? PAR_IN[INPUTS_NUM-1-i] : PAR_IN[i];
      end
    end else if (busy) begin
      if (at_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        under_d = 1'b1;
      end else begin
        cnt_d = cnt_q + STAGES_NUM'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      under_q <= under_d;
    end
  end

  // Flat tree bus: rank k occupies INPUTS_NUM>>k bits starting at 2N - 2(N>>k).
  wire [TREE_W-1:0] tree_w;
  assign tree_w[INPUTS_NUM-1:0] = word_q;

  for (genvar k = 1; k <= STAGES_NUM; k++) begin : g_stage
    localparam int W_IN    = INPUTS_NUM >> (k - 1);
    localparam int OFF_IN  = 2 * INPUTS_NUM - 2 * W_IN;
    localparam int OFF_OUT = OFF_IN + W_IN;
    logic sel;

    if (k == 1) begin : g_sel_direct
      assign sel = cnt_q[0];
    end else begin : g_sel_delay
      // Counter bit k-1 lags k-1 cycles so it meets its word slice at rank k.
      logic [k-2:0] dly_q;
      always_ff @(posedge CLK) begin
        if (RESET) begin
          dly_q <= '0;
        end else begin
          dly_q <= (k-1)'({dly_q, cnt_q[k-1]});
        end
      end
      assign sel = dly_q[k-2];
    end

    tree_ser_stage #(.WIDTH_IN(W_IN)) u_stage (
      .CLK   (CLK),
      .RESET (RESET),
      .SEL   (sel),
      .D     (tree_w[OFF_IN +: W_IN]),
      .Q     (tree_w[OFF_OUT +: W_IN/2])
    );
  end

  flag_t flag_in;
  flag_t flag_q [STAGES_NUM];

  assign flag_in = '{valid: busy, first: busy & (cnt_q == '0)};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < STAGES_NUM; i++) begin
        flag_q[i] <= '0;
      end
    end else begin
      flag_q[0] <= flag_in;
      for (int i = 1; i < STAGES_NUM; i++) begin
        flag_q[i] <= flag_q[i-1];
      end
    end
  end

  assign SERIAL_VALID = flag_q[STAGES_NUM-1].valid;
  assign SERIAL_FIRST = flag_q[STAGES_NUM-1].first;
  assign SERIAL_OUT   = tree_w[TREE_W-1] & flag_q[STAGES_NUM-1].valid;
  assign UNDERRUN     = under_q;

endmodule

`default_nettype wire

// File: tb/tb_tree_serializer_hs.sv
// ============================================================================
// tb_tree_serializer_hs : scoreboard bench for N=16, N=2 and N=64 serializers
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tree_serializer_hs;

  localparam int NS [3] = '{16, 2, 64};
  localparam int SS [3] = '{4, 1, 6};

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] par_in [3];
  logic [2:0]  par_valid;
  logic [2:0]  msb;
  wire  [2:0]  rdy, sout, sval, sfirst, und;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic b;
    logic f;
    int   due;
  } exp_t;

  exp_t q [3][$];
  logic mbusy [3];
  int   mcnt  [3];
  logic uexp  [3];

  int          val_cnt0   = 0;
  int          first_cnt0 = 0;
  int          und_cnt0   = 0;
  logic [31:0] cap0       = '0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = NS[g];
    logic [N-1:0] pin;
    assign pin = par_in[g][N-1:0];
    tree_serializer_hs #(.INPUTS_NUM(N)) u_dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PAR_IN       (pin),
      .PAR_VALID    (par_valid[g]),
      .PAR_READY    (rdy[g]),
      .MSB_FIRST    (msb[g]),
      .SERIAL_OUT   (sout[g]),
      .SERIAL_VALID (sval[g]),
      .SERIAL_FIRST (sfirst[g]),
      .UNDERRUN     (und[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model and scoreboard, evaluated mid-cycle for every DUT.
  always @(negedge CLK) begin
    exp_t e;
    logic rexp, acc;
    int   n;
    for (int i = 0; i < 3; i++) begin
      n    = NS[i];
      rexp = !RESET && (!mbusy[i] || (mcnt[i] == n - 1));
      check($sformatf("ready[%0d]", i), 64'(rdy[i]), 64'(rexp));
      check($sformatf("underrun[%0d]", i), 64'(und[i]), 64'(uexp[i]));
      if (i == 0 && und[0]) und_cnt0++;
      if (q[i].size() > 0 && q[i][0].due == cyc) begin
        e = q[i].pop_front();
        check($sformatf("bit[%0d]@%0d", i, cyc), 64'({sval[i], sout[i], sfirst[i]}),
              64'({1'b1, e.b, e.f}));
        if (i == 0) begin
          val_cnt0++;
          if (sfirst[0]) first_cnt0++;
          cap0 = {cap0[30:0], sout[0]};
        end
      end else begin
        check($sformatf("idle[%0d]@%0d", i, cyc), 64'({sval[i], sout[i], sfirst[i]}), 64'd0);
        if (i == 0 && sval[0]) val_cnt0++;
      end
      acc = par_valid[i] && rexp;
      if (RESET) begin
        q[i].delete();
        mbusy[i] = 1'b0;
        mcnt[i]  = 0;
        uexp[i]  = 1'b0;
      end else begin
        uexp[i] = mbusy[i] && (mcnt[i] == n - 1) && !acc;
        if (acc) begin
          for (int j = 0; j < n; j++) begin
            e.b   = msb[i] ? par_in[i][n-1-j] : par_in[i][j];
            e.f   = (j == 0);
            e.due = cyc + 1 + SS[i] + j;
            q[i].push_back(e);
          end
          mbusy[i] = 1'b1;
          mcnt[i]  = 0;
        end else if (mbusy[i]) begin
          if (mcnt[i] == n - 1) mbusy[i] = 1'b0;
          else mcnt[i]++;
        end
      end
    end
  end

  task automatic drain(input int maxc);
    int c = 0;
    while (c < maxc && (q[0].size() + q[1].size() + q[2].size()) > 0) begin
      tick();
      c++;
    end
    check("drain_bound", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
  endtask

  task automatic send0(input logic [15:0] w, input logic m);
    par_in[0]    = 64'(w);
    msb[0]       = m;
    par_valid[0] = 1'b1;
    tick();
    par_valid[0] = 1'b0;
  endtask

  initial begin
    int v0, f0, u0;
    for (int i = 0; i < 3; i++) begin
      par_in[i] = '0;
      mbusy[i]  = 1'b0;
      mcnt[i]   = 0;
      uexp[i]   = 1'b0;
    end
    par_valid = '0;
    msb       = '0;
    RESET     = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 64'({rdy[0], sout[0], sval[0], sfirst[0], und[0]}), 64'd0);
    RESET = 1'b0;
    #1;
    check("ready_after_reset", 64'(rdy[0]), 64'd1);

    // LSB-first single word
    v0 = val_cnt0; f0 = first_cnt0; u0 = und_cnt0;
    send0(16'hA5C3, 1'b0);
    drain(40);
    check("t1_stream", 64'(cap0[15:0]), 64'h C3A5);
    check("t1_bits", 64'(val_cnt0 - v0), 64'd16);
    check("t1_first", 64'(first_cnt0 - f0), 64'd1);
    check("t1_underrun", 64'(und_cnt0 - u0), 64'd1);

    // MSB-first single word
    v0 = val_cnt0; f0 = first_cnt0; u0 = und_cnt0;
    send0(16'hA5C3, 1'b1);
    drain(40);
    check("t2_stream", 64'(cap0[15:0]), 64'h A5C3);
    check("t2_bits", 64'(val_cnt0 - v0), 64'd16);
    check("t2_first", 64'(first_cnt0 - f0), 64'd1);

    // Back-to-back words with PAR_VALID held high
    v0 = val_cnt0; f0 = first_cnt0; u0 = und_cnt0;
    par_in[0] = 64'h0001; msb[0] = 1'b0; par_valid[0] = 1'b1;
    tick();
    par_in[0] = 64'h8000;
    repeat (16) tick();
    par_valid[0] = 1'b0;
    drain(60);
    check("t3_stream", 64'(cap0), 64'h8000_0001);
    check("t3_bits", 64'(val_cnt0 - v0), 64'd32);
    check("t3_first", 64'(first_cnt0 - f0), 64'd2);
    check("t3_underrun", 64'(und_cnt0 - u0), 64'd1);

    // Reset seven cycles into a word
    send0(16'hFFFF, 1'b0);
    repeat (7) tick();
    RESET = 1'b1;
    tick();
    check("t4_outputs", 64'({rdy[0], sout[0], sval[0], sfirst[0], und[0]}), 64'd0);
    v0    = val_cnt0;
    RESET = 1'b0;
    #1;
    check("t4_ready", 64'(rdy[0]), 64'd1);
    repeat (30) tick();
    check("t4_no_bits", 64'(val_cnt0 - v0), 64'd0);

    // Valid during reset is not accepted
    v0 = val_cnt0;
    RESET = 1'b1; par_in[0] = 64'hBEEF; par_valid[0] = 1'b1;
    tick();
    check("t5_ready_in_reset", 64'(rdy[0]), 64'd0);
    RESET = 1'b0; par_valid[0] = 1'b0;
    tick();
    send0(16'h1234, 1'b0);
    drain(40);
    check("t5_stream", 64'(cap0[15:0]), 64'h2C48);
    check("t5_bits", 64'(val_cnt0 - v0), 64'd16);

    // Random words with random gaps on all three widths
    repeat (400) begin
      for (int i = 0; i < 3; i++) begin
        par_valid[i] = ($urandom_range(0, 2) != 0);
        par_in[i]    = {$urandom, $urandom};
        msb[i]       = 1'($urandom_range(0, 1));
      end
      tick();
    end
    par_valid = '0;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
